// File: rtl/alu_operand_stage.sv
// alu_operand_stage: decode->execute pipeline register in front of the 16-bit ALU.
// Captures a decoded op, resolves EX/WB operand forwarding at capture, applies the
// immediate mux, and holds up to two ops (main + skid) behind a valid/ready handshake.
// Outputs toward the ALU are driven from the main entry only.
//
// Ports:
//   clk, rst (async, active-high), flush (sync kill of held ops)
//   in_valid / in_ready                 decode-side handshake (in_ready registered)
//   in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data, in_imm, in_use_imm,
//   in_alu_control, in_rd_addr, in_reg_write      decoded op
//   ex_fwd_we/addr/data, wb_fwd_we/addr/data      forwarding sources (EX beats WB)
//   out_valid / out_ready               ALU-side handshake
//   alu_a, alu_b, alu_control, out_rd_addr, out_reg_write   op toward ALU
//
// Build option: define ALU_STAGE_PERF_EN to add parameter CNT_W and the
// perf_issued / perf_stall counter outputs.

module alu_operand_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 3
`ifdef ALU_STAGE_PERF_EN
    ,
    parameter int unsigned CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs1_addr,
    input  logic [REG_AW-1:0] in_rs2_addr,
    input  logic [DATA_W-1:0] in_rs1_data,
    input  logic [DATA_W-1:0] in_rs2_data,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_use_imm,
    input  logic [2:0]        in_alu_control,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic              in_reg_write,
    input  logic              ex_fwd_we,
    input  logic [REG_AW-1:0] ex_fwd_addr,
    input  logic [DATA_W-1:0] ex_fwd_data,
    input  logic              wb_fwd_we,
    input  logic [REG_AW-1:0] wb_fwd_addr,
    input  logic [DATA_W-1:0] wb_fwd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_control,
    output logic [REG_AW-1:0] out_rd_addr,
    output logic              out_reg_write
`ifdef ALU_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_issued,
    output logic [CNT_W-1:0]  perf_stall
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t state, state_next;

    logic              accept;
    logic              drain;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;

    // Skid entry payload
    logic [DATA_W-1:0] skid_a;
    logic [DATA_W-1:0] skid_b;
    logic [2:0]        skid_control;
    logic [REG_AW-1:0] skid_rd_addr;
    logic              skid_reg_write;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // Operand resolution at capture: EX beats WB beats register file; imm overrides src2
    always_comb begin
        src_a = in_rs1_data;
        if (ex_fwd_we && (ex_fwd_addr == in_rs1_addr)) begin
            src_a = ex_fwd_data;
        end else if (wb_fwd_we && (wb_fwd_addr == in_rs1_addr)) begin
            src_a = wb_fwd_data;
        end

        src_b = in_rs2_data;
        if (ex_fwd_we && (ex_fwd_addr == in_rs2_addr)) begin
            src_b = ex_fwd_data;
        end else if (wb_fwd_we && (wb_fwd_addr == in_rs2_addr)) begin
            src_b = wb_fwd_data;
        end
        if (in_use_imm) begin
            src_b = in_imm;
        end
    end

    // Occupancy state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next occupancy and entry load controls
    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_next   = ST_ONE;
                    load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && !drain) begin
                    state_next = ST_TWO;
                    load_skid  = 1'b1;
                end else if (accept && drain) begin
                    load_main_in = 1'b1;
                end else if (drain) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (drain) begin
                    state_next     = ST_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
        // Flush discards held ops and any op accepted this cycle
        if (flush) begin
            state_next     = ST_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // Handshake flags registered from the next occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            out_valid <= (state_next != ST_EMPTY);
            in_ready  <= (state_next != ST_TWO);
        end
    end

    // Main entry drives the ALU directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a         <= '0;
            alu_b         <= '0;
            alu_control   <= '0;
            out_rd_addr   <= '0;
            out_reg_write <= 1'b0;
        end else if (load_main_in) begin
            alu_a         <= src_a;
            alu_b         <= src_b;
            alu_control   <= in_alu_control;
            out_rd_addr   <= in_rd_addr;
            out_reg_write <= in_reg_write;
        end else if (load_main_skid) begin
            alu_a         <= skid_a;
            alu_b         <= skid_b;
            alu_control   <= skid_control;
            out_rd_addr   <= skid_rd_addr;
            out_reg_write <= skid_reg_write;
        end
    end

    // Skid entry holds the op accepted while the ALU is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_a         <= '0;
            skid_b         <= '0;
            skid_control   <= '0;
            skid_rd_addr   <= '0;
            skid_reg_write <= 1'b0;
        end else if (load_skid) begin
            skid_a         <= src_a;
            skid_b         <= src_b;
            skid_control   <= in_alu_control;
            skid_rd_addr   <= in_rd_addr;
            skid_reg_write <= in_reg_write;
        end
    end

`ifdef ALU_STAGE_PERF_EN
    // Issue and stall counters; wrap naturally, untouched by flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (drain) begin
                perf_issued <= perf_issued + CNT_W'(1);
            end
            if (out_valid && !out_ready) begin
                perf_stall <= perf_stall + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Testbench for alu_operand_stage: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the stage.
// Define ALU_STAGE_PERF_EN to also exercise the perf counters.

module tb_alu_operand_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_rs1_addr;
    logic [2:0]  in_rs2_addr;
    logic [15:0] in_rs1_data;
    logic [15:0] in_rs2_data;
    logic [15:0] in_imm;
    logic        in_use_imm;
    logic [2:0]  in_alu_control;
    logic [2:0]  in_rd_addr;
    logic        in_reg_write;
    logic        ex_fwd_we;
    logic [2:0]  ex_fwd_addr;
    logic [15:0] ex_fwd_data;
    logic        wb_fwd_we;
    logic [2:0]  wb_fwd_addr;
    logic [15:0] wb_fwd_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_control;
    logic [2:0]  out_rd_addr;
    logic        out_reg_write;
`ifdef ALU_STAGE_PERF_EN
    logic [15:0] perf_issued;
    logic [15:0] perf_stall;
    logic [15:0] exp_issued;
    logic [15:0] exp_stall;
`endif

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  ctl;
        logic [2:0]  rd;
        logic        we;
    } op_t;

    op_t model_q[$];
    int  n_checks;
    int  n_fail;

    alu_operand_stage dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rs1_addr   (in_rs1_addr),
        .in_rs2_addr   (in_rs2_addr),
        .in_rs1_data   (in_rs1_data),
        .in_rs2_data   (in_rs2_data),
        .in_imm        (in_imm),
        .in_use_imm    (in_use_imm),
        .in_alu_control(in_alu_control),
        .in_rd_addr    (in_rd_addr),
        .in_reg_write  (in_reg_write),
        .ex_fwd_we     (ex_fwd_we),
        .ex_fwd_addr   (ex_fwd_addr),
        .ex_fwd_data   (ex_fwd_data),
        .wb_fwd_we     (wb_fwd_we),
        .wb_fwd_addr   (wb_fwd_addr),
        .wb_fwd_data   (wb_fwd_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_control   (alu_control),
        .out_rd_addr   (out_rd_addr),
        .out_reg_write (out_reg_write)
`ifdef ALU_STAGE_PERF_EN
        ,
        .perf_issued   (perf_issued),
        .perf_stall    (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value a source register resolves to, by the stated forwarding priority
    function automatic logic [15:0] fwd_value(input logic [2:0] addr, input logic [15:0] rf);
        if (ex_fwd_we && ex_fwd_addr == addr) return ex_fwd_data;
        if (wb_fwd_we && wb_fwd_addr == addr) return wb_fwd_data;
        return rf;
    endfunction

    task automatic set_idle();
        flush          = 1'b0;
        in_valid       = 1'b0;
        in_rs1_addr    = 3'd0;
        in_rs2_addr    = 3'd0;
        in_rs1_data    = 16'h0;
        in_rs2_data    = 16'h0;
        in_imm         = 16'h0;
        in_use_imm     = 1'b0;
        in_alu_control = 3'd0;
        in_rd_addr     = 3'd0;
        in_reg_write   = 1'b0;
        ex_fwd_we      = 1'b0;
        ex_fwd_addr    = 3'd0;
        ex_fwd_data    = 16'h0;
        wb_fwd_we      = 1'b0;
        wb_fwd_addr    = 3'd0;
        wb_fwd_data    = 16'h0;
    endtask

    // Offer an op with no forwarding: rs1 = r1, rs2 = r2
    task automatic set_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] ctl);
        set_idle();
        in_valid       = 1'b1;
        in_rs1_addr    = 3'd1;
        in_rs2_addr    = 3'd2;
        in_rs1_data    = a;
        in_rs2_data    = b;
        in_alu_control = ctl;
        in_rd_addr     = 3'd5;
        in_reg_write   = 1'b1;
    endtask

    // Advance one clock (negedge to negedge) and update the reference model
    task automatic step();
        logic acc;
        logic drn;
        op_t  op;
        acc    = in_valid && (model_q.size() < 2);
        drn    = (model_q.size() != 0) && out_ready;
        op.a   = fwd_value(in_rs1_addr, in_rs1_data);
        op.b   = in_use_imm ? in_imm : fwd_value(in_rs2_addr, in_rs2_data);
        op.ctl = in_alu_control;
        op.rd  = in_rd_addr;
        op.we  = in_reg_write;
`ifdef ALU_STAGE_PERF_EN
        if (drn) exp_issued = exp_issued + 16'd1;
        if (model_q.size() != 0 && !out_ready) exp_stall = exp_stall + 16'd1;
`endif
        @(posedge clk);
        if (flush) begin
            model_q.delete();
        end else begin
            if (drn) void'(model_q.pop_front());
            if (acc) model_q.push_back(op);
        end
        @(negedge clk);
    endtask

    task automatic clear_model();
        model_q.delete();
`ifdef ALU_STAGE_PERF_EN
        exp_issued = 16'd0;
        exp_stall  = 16'd0;
`endif
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        out_ready = 1'b0;
        set_idle();
        clear_model();
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_a !== 16'h0 || alu_b !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b alu_a=%h alu_b=%h, expected 0 1 0000 0000",
                     out_valid, in_ready, alu_a, alu_b);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        set_op(16'h0005, 16'h0003, 3'b000);
        step();
        n_checks++;
        if (out_valid !== 1'b1 || alu_a !== 16'h0005 || alu_b !== 16'h0003 || alu_control !== 3'b000
            || out_rd_addr !== 3'd5 || out_reg_write !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_pass: v=%b a=%h b=%h ctl=%b rd=%0d we=%b, expected 1 0005 0003 000 5 1",
                     out_valid, alu_a, alu_b, alu_control, out_rd_addr, out_reg_write);
        end
        set_idle();
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drain: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_forward_priority();
        out_ready = 1'b1;
        set_op(16'hAAAA, 16'h0001, 3'b001);
        in_rs1_addr = 3'd2;
        in_rs2_addr = 3'd6;
        ex_fwd_we = 1'b1; ex_fwd_addr = 3'd2; ex_fwd_data = 16'h1111;
        wb_fwd_we = 1'b1; wb_fwd_addr = 3'd2; wb_fwd_data = 16'h2222;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || alu_a !== 16'h1111) begin
            n_fail++;
            $display("FAIL fwd_ex_over_wb: v=%b alu_a=%h expected 1 1111", out_valid, alu_a);
        end
        ex_fwd_addr = 3'd3;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || alu_a !== 16'h2222 || alu_b !== 16'h0001) begin
            n_fail++;
            $display("FAIL fwd_wb_only: v=%b alu_a=%h alu_b=%h expected 1 2222 0001", out_valid, alu_a, alu_b);
        end
        set_idle();
        step();
    endtask

    task automatic test_immediate();
        out_ready = 1'b1;
        set_op(16'h0007, 16'h0044, 3'b010);
        in_rs2_addr = 3'd4;
        in_use_imm  = 1'b1;
        in_imm      = 16'hFFF0;
        ex_fwd_we = 1'b1; ex_fwd_addr = 3'd4; ex_fwd_data = 16'h1234;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || alu_b !== 16'hFFF0) begin
            n_fail++;
            $display("FAIL imm_over_fwd: v=%b alu_b=%h expected 1 fff0", out_valid, alu_b);
        end
        in_use_imm = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || alu_b !== 16'h1234) begin
            n_fail++;
            $display("FAIL fwd_rs2: v=%b alu_b=%h expected 1 1234", out_valid, alu_b);
        end
        set_idle();
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        set_op(16'h0001, 16'h0101, 3'b011);
        step();
        set_op(16'h0002, 16'h0202, 3'b100);
        step();
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || alu_a !== 16'h0001) begin
            n_fail++;
            $display("FAIL bp_full: in_ready=%b v=%b alu_a=%h expected 0 1 0001", in_ready, out_valid, alu_a);
        end
        set_op(16'h0003, 16'h0303, 3'b111);
        step();
        n_checks++;
        if (in_ready !== 1'b0 || alu_a !== 16'h0001 || alu_b !== 16'h0101 || alu_control !== 3'b011) begin
            n_fail++;
            $display("FAIL bp_stable: in_ready=%b a=%h b=%h ctl=%b expected 0 0001 0101 011",
                     in_ready, alu_a, alu_b, alu_control);
        end
        out_ready = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || alu_a !== 16'h0002 || alu_control !== 3'b100) begin
            n_fail++;
            $display("FAIL bp_order2: v=%b a=%h ctl=%b expected 1 0002 100", out_valid, alu_a, alu_control);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b1 || alu_a !== 16'h0003 || alu_b !== 16'h0303) begin
            n_fail++;
            $display("FAIL bp_order3: v=%b a=%h b=%h expected 1 0003 0303", out_valid, alu_a, alu_b);
        end
        set_idle();
        step();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_empty: v=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        set_op(16'h0010, 16'h0000, 3'b000);
        step();
        set_op(16'h0020, 16'h0000, 3'b000);
        step();
        set_op(16'h0030, 16'h0000, 3'b000);
        flush = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_full: v=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        set_idle();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_no_resurrect: cycle %0d v=%b a=%h expected v=0", i, out_valid, alu_a);
            end
        end
        // One held op plus a same-cycle accept: both discarded
        out_ready = 1'b0;
        set_op(16'h0040, 16'h0000, 3'b000);
        step();
        set_op(16'h0050, 16'h0000, 3'b000);
        flush = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_accept: v=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        set_idle();
        out_ready = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_accept_drop: v=%b a=%h expected v=0", out_valid, alu_a);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        set_op(16'h00AA, 16'h00A1, 3'b001);
        step();
        set_op(16'h00BB, 16'h00B1, 3'b010);
        step();
        set_idle();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_a !== 16'h0 || alu_b !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_async: v=%b in_ready=%b a=%h b=%h expected 0 1 0000 0000",
                     out_valid, in_ready, alu_a, alu_b);
        end
`ifdef ALU_STAGE_PERF_EN
        n_checks++;
        if (perf_issued !== 16'h0 || perf_stall !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_perf: issued=%0d stall=%0d expected 0 0", perf_issued, perf_stall);
        end
`endif
        clear_model();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

`ifdef ALU_STAGE_PERF_EN
    task automatic test_perf();
        rst = 1'b1;
        set_idle();
        clear_model();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        set_op(16'h0001, 16'h0000, 3'b000);
        step();
        set_op(16'h0002, 16'h0000, 3'b000);
        step();
        set_idle();
        repeat (3) step();
        out_ready = 1'b1;
        set_op(16'h0003, 16'h0000, 3'b000);
        step();
        step();
        set_idle();
        step();
        n_checks++;
        if (perf_stall !== 16'd4 || perf_issued !== 16'd3) begin
            n_fail++;
            $display("FAIL perf_counts: stall=%0d issued=%0d expected 4 3", perf_stall, perf_issued);
        end
    endtask
`endif

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            n_checks++;
            if (out_valid !== (model_q.size() != 0) || in_ready !== (model_q.size() < 2)) begin
                n_fail++;
                $display("FAIL rand_flags: cycle %0d v=%b in_ready=%b model depth %0d",
                         cyc, out_valid, in_ready, model_q.size());
            end
            if (model_q.size() != 0) begin
                n_checks++;
                if (alu_a !== model_q[0].a || alu_b !== model_q[0].b || alu_control !== model_q[0].ctl
                    || out_rd_addr !== model_q[0].rd || out_reg_write !== model_q[0].we) begin
                    n_fail++;
                    $display("FAIL rand_data: cycle %0d got a=%h b=%h ctl=%b rd=%0d we=%b expected a=%h b=%h ctl=%b rd=%0d we=%b",
                             cyc, alu_a, alu_b, alu_control, out_rd_addr, out_reg_write,
                             model_q[0].a, model_q[0].b, model_q[0].ctl, model_q[0].rd, model_q[0].we);
                end
            end
            in_valid       = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 2) != 0);
            flush          = ($urandom_range(0, 19) == 0);
            in_rs1_addr    = 3'($urandom_range(0, 7));
            in_rs2_addr    = 3'($urandom_range(0, 7));
            in_rs1_data    = 16'($urandom);
            in_rs2_data    = 16'($urandom);
            in_imm         = 16'($urandom);
            in_use_imm     = 1'($urandom_range(0, 1));
            in_alu_control = 3'($urandom_range(0, 7));
            in_rd_addr     = 3'($urandom_range(0, 7));
            in_reg_write   = 1'($urandom_range(0, 1));
            ex_fwd_we      = 1'($urandom_range(0, 1));
            ex_fwd_addr    = ($urandom_range(0, 1) != 0) ? in_rs1_addr : 3'($urandom_range(0, 7));
            ex_fwd_data    = 16'($urandom);
            wb_fwd_we      = 1'($urandom_range(0, 1));
            wb_fwd_addr    = ($urandom_range(0, 1) != 0) ? in_rs2_addr : in_rs1_addr;
            wb_fwd_data    = 16'($urandom);
            step();
        end
        set_idle();
`ifdef ALU_STAGE_PERF_EN
        n_checks++;
        if (perf_issued !== exp_issued || perf_stall !== exp_stall) begin
            n_fail++;
            $display("FAIL rand_perf: issued=%0d stall=%0d expected %0d %0d",
                     perf_issued, perf_stall, exp_issued, exp_stall);
        end
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_forward_priority();
        test_immediate();
        test_backpressure();
        test_flush();
        test_reset_midstream();
`ifdef ALU_STAGE_PERF_EN
        test_perf();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
